// File: rtl/gridding_sequencer.sv
// Gridding sequencer: walks visibility samples, steps the SSIZE kernel rows of
// each one into the complex multiplier array, and delays the grid write address
// by the multiplier latency so it lines up with the products.
module gridding_sequencer #(
  parameter int BRAM_PARALLELISM_BITS = 4,
  parameter int BRAM_DEPTH_BITS       = 10,
  parameter int SSIZE                 = 15,
  parameter int GSIZE                 = 32,
  parameter int CADDR_W               = 10,
  parameter int COFF_W                = 6,
  parameter int MUL_LAT               = 6,
  parameter int ADDR_W                = BRAM_DEPTH_BITS + BRAM_PARALLELISM_BITS
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [ADDR_W-1:0]  nsamp,
  output logic               busy,
  output logic               done,
  output logic [ADDR_W-1:0]  inaddr,
  input  logic [ADDR_W-1:0]  gbase,
  input  logic [COFF_W-1:0]  coff,
  output logic               mul_valid,
  output logic [CADDR_W-1:0] cfaddr,
  output logic               out_valid,
  output logic [ADDR_W-1:0]  outaddr
);

  // One counter serves both the row walk and the drain wait.
  localparam int CNT_W = $clog2((SSIZE > MUL_LAT ? SSIZE : MUL_LAT) + 1);

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_LOAD, S_ROW, S_DRAIN} state_e;

  state_e                          state_q, state_d;
  logic [CNT_W-1:0]                cnt_q, cnt_d;
  logic [ADDR_W-1:0]               left_q, left_d;
  logic [ADDR_W-1:0]               inaddr_q, inaddr_d;
  logic [ADDR_W-1:0]               gbase_q, gbase_d;
  logic [COFF_W-1:0]               coff_q, coff_d;
  logic                            done_q, done_d;
  logic [MUL_LAT-1:0]              vld_pipe_q, vld_pipe_d;
  logic [MUL_LAT-1:0][ADDR_W-1:0]  addr_pipe_q, addr_pipe_d;
  logic [ADDR_W-1:0]               issue_addr;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Datapath registers: counters, latched sample metadata, latency delay line
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q       <= '0;
      left_q      <= '0;
      inaddr_q    <= '0;
      gbase_q     <= '0;
      coff_q      <= '0;
      done_q      <= 1'b0;
      vld_pipe_q  <= '0;
      addr_pipe_q <= '0;
    end else begin
      cnt_q       <= cnt_d;
      left_q      <= left_d;
      inaddr_q    <= inaddr_d;
      gbase_q     <= gbase_d;
      coff_q      <= coff_d;
      done_q      <= done_d;
      vld_pipe_q  <= vld_pipe_d;
      addr_pipe_q <= addr_pipe_d;
    end
  end

  // Next state and next datapath values; start is only looked at in IDLE
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    left_d   = left_q;
    inaddr_d = inaddr_q;
    gbase_d  = gbase_q;
    coff_d   = coff_q;
    done_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (nsamp != '0) begin
            left_d   = nsamp;
            inaddr_d = '0;
            state_d  = S_ADDR;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      S_ADDR: state_d = S_LOAD;
      S_LOAD: begin
        // BRAM output for inaddr is valid this cycle
        gbase_d = gbase;
        coff_d  = coff;
        cnt_d   = '0;
        state_d = S_ROW;
      end
      S_ROW: begin
        if (cnt_q == CNT_W'(SSIZE - 1)) begin
          cnt_d = '0;
          if (left_q > ADDR_W'(1)) begin
            left_d   = left_q - ADDR_W'(1);
            inaddr_d = inaddr_q + ADDR_W'(1);
            state_d  = S_ADDR;
          end else begin
            state_d = S_DRAIN;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DRAIN: begin
        // Last product leaves the multiplier this cycle; done follows it
        if (cnt_q == CNT_W'(MUL_LAT - 1)) begin
          cnt_d   = '0;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs; addresses are forced to 0 whenever their valid is low
  always_comb begin
    busy       = (state_q != S_IDLE);
    done       = done_q;
    inaddr     = inaddr_q;
    mul_valid  = (state_q == S_ROW);
    cfaddr     = mul_valid ? CADDR_W'(coff_q) * CADDR_W'(SSIZE) + CADDR_W'(cnt_q) : '0;
    issue_addr = mul_valid ? gbase_q + ADDR_W'(cnt_q) * ADDR_W'(GSIZE) : '0;
    out_valid  = vld_pipe_q[MUL_LAT-1];
    outaddr    = out_valid ? addr_pipe_q[MUL_LAT-1] : '0;
  end

  // Delay line shifting {mul_valid, grid address} by MUL_LAT cycles
  always_comb begin
    vld_pipe_d     = '0;
    addr_pipe_d    = '0;
    vld_pipe_d[0]  = mul_valid;
    addr_pipe_d[0] = issue_addr;
    for (int i = 1; i < MUL_LAT; i++) begin
      vld_pipe_d[i]  = vld_pipe_q[i-1];
      addr_pipe_d[i] = addr_pipe_q[i-1];
    end
  end

endmodule

// File: tb/tb_gridding_sequencer.sv
// Directed bench for gridding_sequencer: table of runs checked cycle by cycle
// against a timeline model, plus zero-length, reset-abort and start-glitch cases.
module tb_gridding_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [13:0] nsamp;
  logic        busy, done, mul_valid, out_valid;
  logic [13:0] inaddr, gbase, outaddr;
  logic [5:0]  coff;
  logic [9:0]  cfaddr;

  int checks = 0;
  int errors = 0;

  // Visibility/metadata BRAM contents for the current run
  logic [13:0] mem_g [0:3];
  logic [5:0]  mem_c [0:3];

  typedef struct {
    int               n;
    logic [2:0][13:0] g;
    logic [2:0][5:0]  c;
    int               done_cyc;
    int               nvalid;
  } vec_t;

  vec_t tbl [4];

  always #5 clk = ~clk;

  assign gbase = mem_g[inaddr[1:0]];
  assign coff  = mem_c[inaddr[1:0]];

  gridding_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .nsamp(nsamp),
    .busy(busy), .done(done), .inaddr(inaddr),
    .gbase(gbase), .coff(coff),
    .mul_valid(mul_valid), .cfaddr(cfaddr),
    .out_valid(out_valid), .outaddr(outaddr)
  );

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, " busy"}, busy, 0);
    chk({tag, " done"}, done, 0);
    chk({tag, " inaddr"}, inaddr, 0);
    chk({tag, " mul_valid"}, mul_valid, 0);
    chk({tag, " cfaddr"}, cfaddr, 0);
    chk({tag, " out_valid"}, out_valid, 0);
    chk({tag, " outaddr"}, outaddr, 0);
  endtask

  // Expected outputs in cycle c of an n-sample run (cycle 0 carries start).
  // Each sample: ADDR, LOAD, then 15 ROW cycles; drain of 6; done after.
  task automatic expect_cycle(input int c, input int n);
    int last, e_in, e_mv, e_cf, e_ov, e_oa, s, k, c2;
    last = 17 * n + 6;
    e_in = (c <= 17 * n) ? (c - 1) / 17 : n - 1;
    e_mv = 0; e_cf = 0; e_ov = 0; e_oa = 0;
    if (c >= 1 && c <= 17 * n) begin
      s = (c - 1) / 17; k = (c - 1) % 17;
      if (k >= 2) begin
        e_mv = 1;
        e_cf = (int'(mem_c[s]) * 15 + k - 2) % 1024;
      end
    end
    c2 = c - 6;
    if (c2 >= 1 && c2 <= 17 * n) begin
      s = (c2 - 1) / 17; k = (c2 - 1) % 17;
      if (k >= 2) begin
        e_ov = 1;
        e_oa = (int'(mem_g[s]) + (k - 2) * 32) % 16384;
      end
    end
    chk($sformatf("c%0d busy", c), busy, (c >= 1 && c <= last) ? 1 : 0);
    chk($sformatf("c%0d done", c), done, (c == last + 1) ? 1 : 0);
    chk($sformatf("c%0d inaddr", c), inaddr, e_in);
    chk($sformatf("c%0d mul_valid", c), mul_valid, e_mv);
    chk($sformatf("c%0d cfaddr", c), cfaddr, e_cf);
    chk($sformatf("c%0d out_valid", c), out_valid, e_ov);
    chk($sformatf("c%0d outaddr", c), outaddr, e_oa);
  endtask

  task automatic load_mem(input int idx);
    for (int i = 0; i < 3; i++) begin
      mem_g[i] = tbl[idx].g[i];
      mem_c[i] = tbl[idx].c[i];
    end
  endtask

  // Full run from table entry idx; glitch pulses start during ROW and DRAIN
  task automatic run(input int idx, input bit glitch);
    int n, ov_cnt, done_at, last;
    n = tbl[idx].n; ov_cnt = 0; done_at = -1; last = 17 * n + 6;
    load_mem(idx);
    @(negedge clk); nsamp = 14'(n); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int c = 1; c <= last + 2; c++) begin
      expect_cycle(c, n);
      if (out_valid) ov_cnt++;
      if (done && done_at < 0) done_at = c;
      start = (glitch && (c == 5 || c == 10 || c == last - 2)) ? 1'b1 : 1'b0;
      nsamp = glitch ? 14'd3 : nsamp;
      @(negedge clk);
    end
    start = 1'b0;
    chk($sformatf("run%0d out_valid count", idx), ov_cnt, tbl[idx].nvalid);
    chk($sformatf("run%0d done cycle", idx), done_at, tbl[idx].done_cyc);
  endtask

  initial begin
    tbl[0] = '{n: 1, g: {14'd0, 14'd0, 14'd100},   c: {6'd0, 6'd0, 6'd3},
               done_cyc: 24, nvalid: 15};
    tbl[1] = '{n: 3, g: {14'd80, 14'd40, 14'd0},   c: {6'd2, 6'd1, 6'd0},
               done_cyc: 58, nvalid: 45};
    tbl[2] = '{n: 1, g: {14'd0, 14'd0, 14'd16380}, c: {6'd0, 6'd0, 6'd0},
               done_cyc: 24, nvalid: 15};
    tbl[3] = '{n: 2, g: {14'd0, 14'd2000, 14'd1000}, c: {6'd0, 6'd10, 6'd63},
               done_cyc: 41, nvalid: 30};
    for (int i = 0; i < 4; i++) begin mem_g[i] = '0; mem_c[i] = '0; end

    rst = 1'b0; start = 1'b0; nsamp = '0;
    @(negedge clk); @(negedge clk);
    chk_idle_zero("reset");
    rst = 1'b1;
    @(negedge clk);

    // Table-driven runs
    for (int i = 0; i < 4; i++) run(i, 1'b0);

    // nsamp = 0: done at cycle 1, nothing else moves
    @(negedge clk); nsamp = '0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("zero done", done, 1);
    chk("zero busy", busy, 0);
    chk("zero mul_valid", mul_valid, 0);
    chk("zero out_valid", out_valid, 0);
    for (int c = 2; c <= 4; c++) begin
      @(negedge clk);
      chk($sformatf("zero c%0d done", c), done, 0);
      chk($sformatf("zero c%0d busy", c), busy, 0);
      chk($sformatf("zero c%0d out_valid", c), out_valid, 0);
    end

    // Reset at cycle 10 of a 2-sample run aborts it
    load_mem(3);
    @(negedge clk); nsamp = 14'd2; start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int c = 1; c < 10; c++) begin
      expect_cycle(c, 2);
      @(negedge clk);
    end
    rst = 1'b0;
    #1;
    chk_idle_zero("abort");
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      chk($sformatf("post-abort c%0d out_valid", c), out_valid, 0);
      chk($sformatf("post-abort c%0d done", c), done, 0);
      chk($sformatf("post-abort c%0d busy", c), busy, 0);
    end
    run(0, 1'b0);

    // start pulses while busy are ignored
    run(0, 1'b1);
    run(1, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gridding_sequencer.md
Name: gridding_sequencer

Overview:
- Controller that drives the SSIZE-wide complex multiplier array of the gridding datapath.
- For each visibility sample it:
  - Issues the sample read address.
  - Latches the sample's grid base address and kernel offset.
  - Steps through the SSIZE kernel rows, presenting one coefficient-row address per cycle.
  - Produces a grid write address delayed by the multiplier latency, so the address arrives aligned with productr/producti.
- Sits between the visibility/coefficient BRAMs and the grid accumulator.

Parameters:
- BRAM_PARALLELISM_BITS, 4, low bits of the BRAM address.
- BRAM_DEPTH_BITS, 10, high bits of the BRAM address; ADDR_W = BRAM_DEPTH_BITS + BRAM_PARALLELISM_BITS.
- SSIZE, 15, kernel rows per sample (2*SUPPORT+1).
- GSIZE, 32, grid row pitch in address units.
- CADDR_W, 10, coefficient-row address width.
- COFF_W, 6, kernel offset index width.
- MUL_LAT, 6, complex multiplier latency in cycles (1..15).

Ports:
- clk, in, 1, clock; all state on rising edge.
- rst, in, 1, asynchronous active-low reset.
- start, in, 1, one-cycle pulse that begins a run.
- nsamp, in, ADDR_W, number of samples in the run; sampled on start.
- busy, out, 1, high from the cycle after an accepted start until done.
- done, out, 1, one-cycle pulse when the run is complete.
- inaddr, out, ADDR_W, visibility/metadata BRAM read address (registered).
- gbase, in, ADDR_W, grid base address of the sample; BRAM output, valid 1 cycle after inaddr.
- coff, in, COFF_W, kernel offset index of the sample; same timing as gbase.
- mul_valid, out, 1, current cycle's coefficients and data are a valid multiplier input.
- cfaddr, out, CADDR_W, coefficient-row address = coff*SSIZE + row, truncated to CADDR_W.
- out_valid, out, 1, mul_valid delayed by MUL_LAT cycles.
- outaddr, out, ADDR_W, grid address gbase + row*GSIZE (mod 2^ADDR_W), delayed MUL_LAT cycles.

Behaviour:
- Reset (rst=0, async): state IDLE. All outputs 0: busy, done, inaddr, mul_valid, cfaddr, out_valid, outaddr. Sample counter, row counter and delay line are cleared.
- Reset during a run aborts it; no further out_valid after release.
- States: IDLE, ADDR, LOAD, ROW, DRAIN.
- IDLE:
  - start=1 and nsamp>0: latch nsamp, set inaddr=0, go to ADDR, set busy.
  - start=1 and nsamp=0: done=1 next cycle; stay IDLE; busy stays 0.
- ADDR: 1 cycle; inaddr is stable and the BRAM is reading. Go to LOAD.
- LOAD: 1 cycle; gbase/coff are valid. Register them at the end of the cycle, clear row, go to ROW.
- ROW: SSIZE cycles, rows 0..SSIZE-1.
  - mul_valid=1.
  - cfaddr = coff_reg*SSIZE + row.
  - Address pair entering the delay line = gbase_reg + row*GSIZE.
  - inaddr is held constant, so data_r/data_i stay stable.
  - After row SSIZE-1:
    - If samples remain: inaddr+1, go to ADDR.
    - Otherwise: go to DRAIN.
- DRAIN: MUL_LAT cycles with mul_valid=0. Then done=1 for one cycle, busy=0, go to IDLE.
- Cost: SSIZE+2 cycles per sample. Total run = nsamp*(SSIZE+2) + MUL_LAT cycles from the first ADDR cycle to done (exclusive).
- Delay line:
  - Shift register of depth MUL_LAT carrying {mul_valid, address}.
  - out_valid/outaddr equal the values issued MUL_LAT cycles earlier.
  - cfaddr and outaddr are 0 whenever the corresponding valid is 0.
- Timing of done: done asserts the cycle after the last out_valid, and never in the same cycle as any out_valid.
- start while busy: ignored; no restart, no error.
- Arithmetic: all additions are unsigned and wrap modulo 2^width. No saturation and no flag.

Test Plan:
- Single sample: nsamp=1, gbase=100, coff=3, start pulse at cycle 0.
  - ADDR at cycle 1, LOAD at 2, mul_valid cycles 3..17 with cfaddr 45..59.
  - out_valid cycles 9..23 with outaddr 100,132,...,548.
  - done at cycle 24; busy high in cycles 1..23.
- Three samples with gbase 0/40/80 and coff 0/1/2:
  - inaddr steps 0,1,2.
  - Each group has 15 mul_valid cycles, separated by 2-cycle gaps.
  - cfaddr groups: 0..14, 15..29, 30..44.
  - done at 3*17+6+1 cycles after start.
- Wrap: gbase=16380, ADDR_W=14 → outaddr 16380, 28 (16412 mod 16384), 60, ... with no error.
- nsamp=0 → done pulses at cycle 1; busy, mul_valid and out_valid stay 0.
- Reset pulled low at cycle 10 of a 2-sample run → all outputs 0 immediately. After release: no out_valid, no done, and a new start behaves as in the single-sample test.
- start reasserted during ROW → ignored; the output sequence is identical to an undisturbed run.
